// File: rtl/guess_game_pkg.sv
// Shared types, glyph codes and hex decoding for the number-guessing engine.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package guess_game_pkg;

   typedef enum logic [1:0] {
      StP1Entry,
      StP2Entry,
      StWin,
      StLose
   } state_e;

   localparam logic [6:0] GlyphP     = 7'h0C;
   localparam logic [6:0] GlyphL     = 7'h47;
   localparam logic [6:0] GlyphDash  = 7'h3F;
   localparam logic [6:0] GlyphH     = 7'h09;
   localparam logic [6:0] GlyphI     = 7'h4F;
   localparam logic [6:0] GlyphO     = 7'h40;
   localparam logic [6:0] GlyphBlank = 7'h7F;

   function automatic logic [6:0] hex2seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player-input and display/status bundle of the guessing engine.
// master drives the player inputs; slave is the engine side.
interface guess_game_if #(
   parameter int unsigned NDIG = 4
);
   logic [3:0]      digit_val;
   logic [NDIG-1:0] digit_load;
   logic            commit;
   logic            new_game;
   logic [6:0]      seg;
   logic            dp;
   logic [NDIG-1:0] an;
   logic [7:0]      led;
   logic            hi;
   logic            lo;
   logic            win;
   logic            lose;
   logic [7:0]      guess_cnt;

   modport master (
      output digit_val, digit_load, commit, new_game,
      input  seg, dp, an, led, hi, lo, win, lose, guess_cnt
   );

   modport slave (
      input  digit_val, digit_load, commit, new_game,
      output seg, dp, an, led, hi, lo, win, lose, guess_cnt
   );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: dwells SCAN_DIV clocks per digit and skips
// blank digits. an and seg are registered together from the current index.
module seg_scan_mux #(
   parameter int unsigned NDIG     = 4,
   parameter int unsigned SCAN_DIV = 25000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      glyph [NDIG],
   input  logic [NDIG-1:0] blank,
   output logic [NDIG-1:0] an,
   output logic [6:0]      seg
);
   import guess_game_pkg::*;

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [PW-1:0] pre_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_nxt;
   logic [IW-1:0] cand;
   logic          found;

   // First non-blank digit after the current one; stays put if all are blank.
   always_comb begin
      idx_nxt = idx_q;
      cand    = idx_q;
      found   = 1'b0;
      for (int unsigned k = 1; k <= NDIG; k++) begin
         cand = IW'((32'(idx_q) + k) % NDIG);
         if (!found && !blank[cand]) begin
            idx_nxt = cand;
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         idx_q <= '0;
         an    <= '1;
         seg   <= GlyphBlank;
      end else begin
         if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= idx_nxt;
         end else begin
            pre_q <= pre_q + 1'b1;
         end
         if (blank[idx_q]) begin
            an  <= '1;
            seg <= GlyphBlank;
         end else begin
            an  <= ~(NDIG'(1) << idx_q);
            seg <= glyph[idx_q];
         end
      end
   end

endmodule

// File: rtl/guess_game_core.sv
// Two-player guessing engine: entry buffer, secret, comparator, guess counter,
// win blink timer and the glyph selection feeding the display scanner.
module guess_game_core #(
   parameter int unsigned NDIG      = 4,
   parameter int unsigned MAX_GUESS = 15,
   parameter int unsigned SCAN_DIV  = 25000,
   parameter int unsigned BLINK_DIV = 5000000
) (
   input logic        clk,
   input logic        rst_n,
   guess_game_if.slave bus
);
   import guess_game_pkg::*;

   localparam int unsigned W  = NDIG * 4;
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [1:0]      rst_sync_q;
   logic            rst_sync_n;
   state_e          state_q;
   logic [W-1:0]    entry_q;
   logic [W-1:0]    secret_q;
   logic [NDIG-1:0] entered_q;
   logic [7:0]      cnt_q;
   logic [7:0]      cnt_inc;
   logic            hi_q, lo_q, win_q, lose_q;
   logic [7:0]      led_q;
   logic [BW-1:0]   blink_q;
   logic            gt, lt, eq;
   logic [6:0]      glyph [NDIG];
   logic [NDIG-1:0] glyph_blank;
   logic [27:0]     text;
   logic            show_text;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_sync_n = rst_sync_q[1];

   assign gt      = entry_q > secret_q;
   assign lt      = entry_q < secret_q;
   assign eq      = entry_q == secret_q;
   assign cnt_inc = (cnt_q >= 8'(MAX_GUESS)) ? cnt_q : cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q   <= StP1Entry;
         entry_q   <= '0;
         secret_q  <= '0;
         entered_q <= '0;
         cnt_q     <= '0;
         {hi_q, lo_q, win_q, lose_q} <= '0;
         led_q     <= '0;
         blink_q   <= '0;
      end else if (bus.new_game) begin
         state_q   <= StP1Entry;
         entry_q   <= '0;
         secret_q  <= '0;
         entered_q <= '0;
         cnt_q     <= '0;
         {hi_q, lo_q, win_q, lose_q} <= '0;
         led_q     <= '0;
         blink_q   <= '0;
      end else begin
         unique case (state_q)
            StP1Entry, StP2Entry: begin
               // Commit wins over a same-cycle load, which is dropped.
               if (bus.commit && (entered_q != '0)) begin
                  entry_q   <= '0;
                  entered_q <= '0;
                  if (state_q == StP1Entry) begin
                     secret_q <= entry_q;
                     state_q  <= StP2Entry;
                  end else begin
                     cnt_q <= cnt_inc;
                     hi_q  <= gt;
                     lo_q  <= lt;
                     if (eq) begin
                        win_q   <= 1'b1;
                        state_q <= StWin;
                        blink_q <= '0;
                        led_q   <= '0;
                     end else if (cnt_inc == 8'(MAX_GUESS)) begin
                        lose_q  <= 1'b1;
                        state_q <= StLose;
                     end
                  end
               end else if (bus.digit_load != '0) begin
                  for (int unsigned i = 0; i < NDIG; i++) begin
                     if (bus.digit_load[i]) entry_q[4*i +: 4] <= bus.digit_val;
                  end
                  entered_q <= entered_q | bus.digit_load;
                  hi_q      <= 1'b0;
                  lo_q      <= 1'b0;
               end
            end
            StWin: begin
               if (blink_q == BW'(BLINK_DIV - 1)) begin
                  blink_q <= '0;
                  led_q   <= ~led_q;
               end else begin
                  blink_q <= blink_q + 1'b1;
               end
            end
            StLose: begin
               led_q <= '0;
            end
         endcase
      end
   end

   // Text glyphs always occupy digits 3..0; higher digits stay blank.
   always_comb begin
      glyph_blank = '1;
      for (int unsigned i = 0; i < NDIG; i++) glyph[i] = GlyphBlank;
      text      = {4{GlyphBlank}};
      show_text = 1'b0;
      unique case (state_q)
         StP1Entry, StP2Entry: begin
            if (hi_q || lo_q) begin
               show_text = 1'b1;
               text = {hex2seg(4'h2), GlyphDash, hi_q ? GlyphH : GlyphL, hi_q ? GlyphI : GlyphO};
            end else if (entered_q == '0) begin
               show_text = 1'b1;
               text = {GlyphP, GlyphL, GlyphDash,
                       hex2seg((state_q == StP1Entry) ? 4'h1 : 4'h2)};
            end else begin
               for (int unsigned i = 0; i < NDIG; i++) glyph[i] = hex2seg(entry_q[4*i +: 4]);
               glyph_blank = '0;
            end
         end
         StWin: begin
            glyph[0]         = hex2seg(cnt_q[3:0]);
            glyph[1]         = hex2seg(cnt_q[7:4]);
            glyph_blank[1:0] = 2'b00;
         end
         StLose: begin
            for (int unsigned i = 0; i < NDIG; i++) glyph[i] = hex2seg(secret_q[4*i +: 4]);
            glyph_blank = '0;
         end
      endcase
      if (show_text) begin
         for (int unsigned i = 0; i < 4; i++) begin
            glyph[i]       = text[7*i +: 7];
            glyph_blank[i] = 1'b0;
         end
      end
   end

   seg_scan_mux #(
      .NDIG     (NDIG),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk   (clk),
      .rst_n (rst_sync_n),
      .glyph (glyph),
      .blank (glyph_blank),
      .an    (bus.an),
      .seg   (bus.seg)
   );

   assign bus.dp        = 1'b1;
   assign bus.led       = led_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.win       = win_q;
   assign bus.lose      = lose_q;
   assign bus.guess_cnt = cnt_q;

endmodule

// File: tb/tb_guess_game_core.sv
// Scoreboard bench for guess_game_core: stimulus queues expected observations
// with a due cycle; a negedge monitor captures the scanned display and compares.
module tb_guess_game_core;
   localparam int unsigned NDIG = 4;

   localparam int KFlags = 0;
   localparam int KCnt   = 1;
   localparam int KLed   = 2;
   localparam int KAn    = 3;
   localparam int KSeg   = 4;
   localparam int KDp    = 5;
   localparam int KFrame = 6;

   localparam logic [6:0] GP = 7'h0C;
   localparam logic [6:0] GL = 7'h47;
   localparam logic [6:0] GD = 7'h3F;
   localparam logic [6:0] GH = 7'h09;
   localparam logic [6:0] GI = 7'h4F;
   localparam logic [6:0] GO = 7'h40;
   localparam logic [6:0] GB = 7'h7F;

   typedef struct {
      string       name;
      int          kind;
      int          due;
      int          start;
      logic [27:0] exp;
   } item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   item_t sb[$];

   int         lit_cyc [NDIG];
   logic [6:0] lit_seg [NDIG];
   logic [NDIG-1:0] prev_an = '1;

   guess_game_if #(.NDIG(NDIG)) bus ();

   guess_game_core #(
      .NDIG      (NDIG),
      .MAX_GUESS (3),
      .SCAN_DIV  (4),
      .BLINK_DIV (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic check_item(input item_t it);
      logic [27:0] act;
      act = '0;
      case (it.kind)
         KFlags: act = 28'({bus.win, bus.lose, bus.hi, bus.lo});
         KCnt:   act = 28'(bus.guess_cnt);
         KLed:   act = 28'(bus.led);
         KAn:    act = 28'(bus.an);
         KSeg:   act = 28'(bus.seg);
         KDp:    act = 28'(bus.dp);
         default: begin
            for (int d = 0; d < NDIG; d++)
               act[7*d +: 7] = (lit_cyc[d] >= it.start) ? lit_seg[d] : GB;
         end
      endcase
      n_vec++;
      if (act !== it.exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", it.name, act, it.exp, cyc);
      end
   endtask

   // Monitor: record the glyph at the first cycle of each lit period, then
   // compare every expectation that has come due.
   initial for (int d = 0; d < NDIG; d++) begin
      lit_cyc[d] = -1;
      lit_seg[d] = GB;
   end

   always @(negedge clk) begin
      int i;
      if (bus.an != prev_an && $onehot(~bus.an)) begin
         for (int d = 0; d < NDIG; d++) begin
            if (!bus.an[d]) begin
               lit_cyc[d] = cyc;
               lit_seg[d] = bus.seg;
            end
         end
      end
      prev_an = bus.an;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due <= cyc) begin
            check_item(sb[i]);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input string name, input int kind, input logic [27:0] exp,
                            input int delay);
      item_t it;
      it.name  = name;
      it.kind  = kind;
      it.due   = cyc + delay;
      it.start = 0;
      it.exp   = exp;
      sb.push_back(it);
   endtask

   task automatic expect_now(input string name, input int kind, input logic [27:0] exp);
      expect_at(name, kind, exp, 0);
   endtask

   task automatic expect_status(input string name, input logic [3:0] flags,
                                input logic [7:0] cnt);
      expect_now({name, "_flags"}, KFlags, 28'(flags));
      expect_now({name, "_cnt"}, KCnt, 28'(cnt));
   endtask

   task automatic frame(input string name, input logic [27:0] exp);
      item_t it;
      it.name  = name;
      it.kind  = KFrame;
      it.start = cyc + 3;
      it.due   = cyc + 23;
      it.exp   = exp;
      sb.push_back(it);
      tick(24);
   endtask

   task automatic load(input int d, input logic [3:0] v);
      bus.digit_load    = '0;
      bus.digit_load[d] = 1'b1;
      bus.digit_val     = v;
      tick(1);
      bus.digit_load    = '0;
   endtask

   task automatic enter(input logic [15:0] v);
      for (int d = NDIG - 1; d >= 0; d--) load(d, v[4*d +: 4]);
   endtask

   task automatic commit_pulse(input logic [NDIG-1:0] ld, input logic [3:0] v);
      bus.commit     = 1'b1;
      bus.digit_load = ld;
      bus.digit_val  = v;
      tick(1);
      bus.commit     = 1'b0;
      bus.digit_load = '0;
   endtask

   task automatic new_game_pulse();
      bus.new_game = 1'b1;
      tick(1);
      bus.new_game = 1'b0;
   endtask

   task automatic check_reset(input string name);
      expect_now({name, "_an"}, KAn, 28'hF);
      expect_now({name, "_seg"}, KSeg, 28'h7F);
      expect_now({name, "_dp"}, KDp, 28'h1);
      expect_now({name, "_led"}, KLed, 28'h0);
      expect_status(name, 4'b0000, 8'd0);
   endtask

   initial begin
      bus.digit_val  = '0;
      bus.digit_load = '0;
      bus.commit     = 1'b0;
      bus.new_game   = 1'b0;
      #2 rst_n = 1'b0;
      tick(2);
      check_reset("por");
      tick(1);
      rst_n = 1'b1;
      tick(3);
      frame("pl1", {GP, GL, GD, seg7(4'h1)});

      // Game 1: secret 1234, HI, LO then win on the third guess.
      commit_pulse('0, 4'h0);
      frame("empty_commit", {GP, GL, GD, seg7(4'h1)});
      enter(16'h1234);
      frame("p1_buf", {seg7(4'h1), seg7(4'h2), seg7(4'h3), seg7(4'h4)});
      commit_pulse('0, 4'h0);
      expect_status("secret", 4'b0000, 8'd0);
      frame("pl2", {GP, GL, GD, seg7(4'h2)});
      enter(16'h2000);
      commit_pulse('0, 4'h0);
      expect_status("g2000", 4'b0010, 8'd1);
      frame("2hi", {seg7(4'h2), GD, GH, GI});
      load(3, 4'h1);
      expect_now("load_clears_hilo", KFlags, 28'h0);
      load(2, 4'h2);
      load(1, 4'h3);
      load(0, 4'h3);
      commit_pulse('0, 4'h0);
      expect_status("g1233", 4'b0001, 8'd2);
      frame("2lo", {seg7(4'h2), GD, GL, GO});
      enter(16'h1234);
      commit_pulse('0, 4'h0);
      expect_status("g1234", 4'b1000, 8'd3);
      expect_at("led_0", KLed, 28'h00, 0);
      expect_at("led_7", KLed, 28'h00, 7);
      expect_at("led_8", KLed, 28'hFF, 8);
      expect_at("led_15", KLed, 28'hFF, 15);
      expect_at("led_16", KLed, 28'h00, 16);
      frame("win03", {GB, GB, seg7(4'h0), seg7(4'h3)});
      load(0, 4'h9);
      commit_pulse('0, 4'h0);
      expect_status("win_locked", 4'b1000, 8'd3);
      new_game_pulse();
      expect_status("ng_win", 4'b0000, 8'd0);
      expect_now("ng_win_led", KLed, 28'h0);
      frame("ng_pl1", {GP, GL, GD, seg7(4'h1)});

      // Game 2: three wrong guesses lose; full-width unsigned compare.
      enter(16'h1234);
      commit_pulse('0, 4'h0);
      enter(16'h0001);
      commit_pulse('0, 4'h0);
      expect_status("l1", 4'b0001, 8'd1);
      enter(16'hFFFF);
      commit_pulse('0, 4'h0);
      expect_status("l2", 4'b0010, 8'd2);
      enter(16'h1235);
      commit_pulse('0, 4'h0);
      expect_status("l3", 4'b0110, 8'd3);
      frame("lose_secret", {seg7(4'h1), seg7(4'h2), seg7(4'h3), seg7(4'h4)});
      load(0, 4'h9);
      commit_pulse('0, 4'h0);
      expect_status("lose_locked", 4'b0110, 8'd3);
      expect_now("lose_led", KLed, 28'h0);
      frame("lose_frame", {seg7(4'h1), seg7(4'h2), seg7(4'h3), seg7(4'h4)});
      new_game_pulse();

      // Game 3: commit with a same-cycle load keeps the pre-load buffer.
      load(0, 4'h5);
      commit_pulse(4'b0001, 4'h7);
      frame("load_dropped", {GP, GL, GD, seg7(4'h2)});
      load(0, 4'h5);
      commit_pulse('0, 4'h0);
      expect_status("g0005", 4'b1000, 8'd1);
      frame("win01", {GB, GB, seg7(4'h0), seg7(4'h1)});

      // Async reset mid-scan while the LEDs are lit.
      for (int i = 0; i < 20 && bus.led != 8'hFF; i++) tick(1);
      expect_now("led_lit_before_rst", KLed, 28'hFF);
      tick(1);
      #1 rst_n = 1'b0;
      check_reset("async");
      tick(1);
      rst_n = 1'b1;
      tick(3);
      frame("rst_pl1", {GP, GL, GD, seg7(4'h1)});

      tick(3);
      while (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: got never-checked, want checked", sb[0].name);
         void'(sb.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

endmodule
